spi_master_mcs: RTL and testbench

Parametrised SPI master, successor to the fixed 8-bit master/slave pair. It supports configurable frame width and up to NCS chip selects, with all four CPOL/CPHA modes selectable per frame. It adds an LSB/MSB-first option and burst frames that keep chip-select asserted. It sits between a register/command block (start/ready/done handshake) and the SPI pins; sclk is derived from the system clock via a programmable divider.

---
 rtl/spi_master_mcs.sv | 177 +++++++++++++++++
 tb/tb_spi_master_mcs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_mcs.sv
// SPI master with configurable frame width, chip-select count, CPOL/CPHA,
// bit order and burst frames that keep chip-select asserted between words.
// Every phase (setup, each sclk half, hold) lasts dvsr+1 clk cycles.
module spi_master_mcs #(
    parameter int DW     = 8,
    parameter int NCS    = 4,
    parameter int DVSR_W = 16,
    localparam int CSW   = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CSW-1:0]    cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              hold_cs,
    input  logic              cs_release,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [DW-1:0]     din,
    input  logic              miso,
    output logic              ready,
    output logic              done,
    output logic [DW-1:0]     dout,
    output logic              sclk,
    output logic              mosi,
    output logic [NCS-1:0]    ss_n
);
    localparam int BW = $clog2(DW);

    typedef enum logic [2:0] {IDLE, SETUP, H0, H1, HOLD, BURST} state_t;

    state_t            state, state_nx;
    logic [DVSR_W-1:0] cnt, dvsr_r;
    logic [BW-1:0]     bit_cnt;
    logic              cpol_r, cpha_r, lsb_r, hold_r;
    logic [DW-1:0]     tx_q, rx_q;
    logic              tick, cs_ok, last_bit;
    logic              accept_idle, accept_burst, accept, release_cs;
    logic              frame_end, sample, shift_out;
    logic              cpol_nx, cpha_nx;

    // Next-state decode plus the per-cycle strobes that drive the datapath
    always_comb begin
        state_nx     = state;
        ready        = 1'b0;
        accept_idle  = 1'b0;
        accept_burst = 1'b0;
        release_cs   = 1'b0;
        tick         = (cnt == dvsr_r);
        cs_ok        = (int'(cs_sel) < NCS);
        last_bit     = (bit_cnt == BW'(DW - 1));
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start && cs_ok) begin
                    accept_idle = 1'b1;
                    state_nx    = SETUP;
                end
            end
            SETUP: if (tick) state_nx = H0;
            H0:    if (tick) state_nx = H1;
            H1:    if (tick) state_nx = last_bit ? HOLD : H0;
            HOLD:  if (tick) state_nx = hold_r ? BURST : IDLE;
            BURST: begin
                ready = 1'b1;
                // a start in the same cycle as a release keeps the slave selected
                if (start) begin
                    accept_burst = 1'b1;
                    state_nx     = H0;
                end else if (cs_release) begin
                    release_cs = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        accept    = accept_idle || accept_burst;
        frame_end = (state == HOLD) && tick;
        // cpha=0 samples on the leading edge (end of H0) and shifts on the trailing
        // edge; cpha=1 is the other way round. No shift after the final bit.
        sample    = tick && (((state == H0) && !cpha_r) || ((state == H1) && cpha_r));
        shift_out = tick && (((state == H0) && cpha_r) ||
                             ((state == H1) && !cpha_r && !last_bit));
        // burst frames keep the polarity/phase of the frame that opened the burst
        cpol_nx   = accept_idle ? cpol : cpol_r;
        cpha_nx   = accept_idle ? cpha : cpha_r;
    end

    // State register with the phase counter and bit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state || state == IDLE || state == BURST)
                cnt <= '0;
            else
                cnt <= cnt + DVSR_W'(1);
            if (accept)
                bit_cnt <= '0;
            else if (state == H1 && tick)
                bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // Frame configuration captured at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpol_r <= 1'b0;
            cpha_r <= 1'b0;
            lsb_r  <= 1'b0;
            hold_r <= 1'b0;
            dvsr_r <= '0;
        end else begin
            if (accept_idle) begin
                cpol_r <= cpol;
                cpha_r <= cpha;
                dvsr_r <= dvsr;
            end
            if (accept) begin
                lsb_r  <= lsb_first;
                hold_r <= hold_cs;
            end
        end
    end

    // Transmit and receive shift registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if (accept) begin
                rx_q <= '0;
                // with cpha=0 the first bit goes out immediately, so preshift
                if (!cpha_nx)
                    tx_q <= lsb_first ? (din >> 1) : (din << 1);
                else
                    tx_q <= din;
            end else if (shift_out) begin
                tx_q <= lsb_r ? (tx_q >> 1) : (tx_q << 1);
            end
            if (sample)
                rx_q <= lsb_r ? {miso, rx_q[DW-1:1]} : {rx_q[DW-2:0], miso};
        end
    end

    // Registered SPI pins and the completion handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk <= 1'b0;
            mosi <= 1'b0;
            ss_n <= '1;
            done <= 1'b0;
            dout <= '0;
        end else begin
            sclk <= (state_nx == H1) ? ~cpol_nx : cpol_nx;
            done <= frame_end;
            if (frame_end)
                dout <= rx_q;
            if (accept_idle)
                ss_n <= ~(NCS'(1) << cs_sel);
            else if ((frame_end && !hold_r) || release_cs)
                ss_n <= '1;
            if (accept) begin
                if (!cpha_nx)
                    mosi <= lsb_first ? din[0] : din[DW-1];
            end else if (shift_out) begin
                mosi <= lsb_r ? tx_q[0] : tx_q[DW-1];
            end
        end
    end

endmodule

// File: tb/tb_spi_master_mcs.sv
// Directed + randomized bench for spi_master_mcs, with a behavioural SPI slave
// that reacts to sclk edges and a spec-derived latency/data reference.
module tb_spi_master_mcs;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic        hold_cs = 1'b0, cs_release = 1'b0;
    logic [1:0]  cs_sel = '0;
    logic [15:0] dvsr = '0;
    logic [7:0]  din = '0;
    logic        miso, ready, done, sclk, mosi;
    logic [7:0]  dout;
    logic [3:0]  ss_n;

    logic        start_b = 1'b0;
    logic [1:0]  cs_sel_b = '0;
    logic [15:0] din_b = '0;
    logic        ready_b, done_b, sclk_b, mosi_b;
    logic [15:0] dout_b;
    logic [2:0]  ss_n_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    spi_master_mcs #(.DW(DW), .NCS(4), .DVSR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .hold_cs(hold_cs), .cs_release(cs_release), .dvsr(dvsr),
        .din(din), .miso(miso), .ready(ready), .done(done), .dout(dout), .sclk(sclk),
        .mosi(mosi), .ss_n(ss_n)
    );

    // 16-bit, 3-select variant in loopback
    spi_master_mcs #(.DW(16), .NCS(3), .DVSR_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cs_sel(cs_sel_b), .cpol(1'b0), .cpha(1'b0),
        .lsb_first(1'b0), .hold_cs(1'b0), .cs_release(1'b0), .dvsr(16'd0),
        .din(din_b), .miso(mosi_b), .ready(ready_b), .done(done_b), .dout(dout_b),
        .sclk(sclk_b), .mosi(mosi_b), .ss_n(ss_n_b)
    );

    // ---------------- behavioural slave ----------------
    logic       loop = 1'b1;
    logic       slv_on = 1'b0, slv_cpol = 1'b0, slv_cpha = 1'b0, slv_lsb = 1'b0;
    logic       slv_out = 1'b0;
    logic [7:0] slv_tx = '0, slv_rx = '0;
    int         slv_lead = 0, slv_trail = 0, slv_nrx = 0, slv_ntx = 0;

    assign miso = loop ? mosi : slv_out;

    function automatic int pos(input int k);
        return slv_lsb ? k : DW - 1 - k;
    endfunction

    task slv_drive();
        if (slv_ntx < DW) begin
            slv_out = slv_tx[pos(slv_ntx)];
            slv_ntx++;
        end
    endtask

    task slv_take();
        if (slv_nrx < DW) begin
            slv_rx[pos(slv_nrx)] = mosi;
            slv_nrx++;
        end
    endtask

    task arm(input logic pol, pha, lsb, input logic [7:0] word);
        slv_on = 1'b0;
        slv_cpol = pol; slv_cpha = pha; slv_lsb = lsb; slv_tx = word;
        slv_rx = '0; slv_lead = 0; slv_trail = 0; slv_nrx = 0; slv_ntx = 0;
        if (!pha) slv_drive();
        slv_on = 1'b1;
    endtask

    // leading edge = sclk leaves its idle level; a trailing edge only counts after a leading one
    always @(sclk) begin
        if (slv_on) begin
            if (sclk !== slv_cpol) begin
                slv_lead++;
                if (slv_cpha) slv_drive(); else slv_take();
            end else if (slv_lead > slv_trail) begin
                slv_trail++;
                if (slv_cpha) slv_take(); else slv_drive();
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame: eff config (pol/pha/dv/cs) is what the frame must use; in a burst the
    // pins carry different values that must be ignored.
    task automatic do_frame(input string tag, input logic [1:0] cs, input logic pol, pha,
                            lsb, hold, burst, lp, input int dv, input logic [7:0] d, sw);
        int         lat;
        logic [3:0] ssx;
        ssx  = 4'hF & ~(4'h1 << cs);
        loop = lp;
        arm(pol, pha, lsb, sw);
        din = d; lsb_first = lsb; hold_cs = hold;
        if (burst) begin
            cs_sel = cs ^ 2'd1; cpol = ~pol; cpha = ~pha; dvsr = 16'(dv + 3);
        end else begin
            cs_sel = cs; cpol = pol; cpha = pha; dvsr = 16'(dv);
        end
        start = 1'b1;
        cyc();
        start = 1'b0; cs_release = 1'b0;
        din = ~d; cpol = ~pol; cpha = ~pha; lsb_first = ~lsb; hold_cs = ~hold;
        chk({tag, " ss_n_active"}, 32'(ss_n), 32'(ssx));
        chk({tag, " ready_busy"}, 32'(ready), 32'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 20000) begin
            cyc();
            lat++;
        end
        chk({tag, " latency"}, lat, (2 * DW + (burst ? 1 : 2)) * (dv + 1));
        chk({tag, " dout"}, 32'(dout), 32'(lp ? d : sw));
        chk({tag, " slave_rx"}, 32'(slv_rx), 32'(d));
        chk({tag, " sclk_edges"}, slv_lead, DW);
        chk({tag, " ready_done"}, 32'(ready), 32'd1);
        chk({tag, " ss_n_after"}, 32'(ss_n), 32'(hold ? ssx : 4'hF));
        chk({tag, " sclk_idle"}, 32'(sclk), 32'(pol));
        cyc();
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        slv_on = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int seen;
        int n;
        #1 rst = 1'b0;
        #1;
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst done", 32'(done), 32'd0);
        chk("rst dout", 32'(dout), 32'd0);
        chk("rst sclk", 32'(sclk), 32'd0);
        chk("rst mosi", 32'(mosi), 32'd0);
        chk("rst ss_n", 32'(ss_n), 32'hF);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        // mode 0, MSB first, 1 MHz sclk, loopback
        do_frame("T1", 2'd0, 0, 0, 0, 0, 0, 1, 49, 8'hA1, 8'h00);
        // mode 3, LSB first, slave answers 0xA6
        do_frame("T2", 2'd1, 1, 1, 1, 0, 0, 0, 3, 8'hA1, 8'hA6);
        // modes 1 and 2 against the slave
        do_frame("T3m1", 2'd3, 0, 1, 0, 0, 0, 0, 2, 8'h5A, 8'h3C);
        do_frame("T3m2", 2'd2, 1, 0, 0, 0, 0, 0, 2, 8'h5A, 8'h3C);

        // burst on cs 2; second frame also raises cs_release, which must lose to start
        do_frame("B1", 2'd2, 0, 0, 0, 1, 0, 1, 2, 8'h12, 8'h00);
        cs_release = 1'b1;
        do_frame("B2", 2'd2, 0, 0, 1, 1, 1, 1, 2, 8'h34, 8'h00);
        do_frame("B3", 2'd2, 0, 0, 0, 1, 1, 0, 2, 8'hC7, 8'h9E);
        cs_release = 1'b1;
        cyc();
        cs_release = 1'b0;
        chk("B release ss_n", 32'(ss_n), 32'hF);
        chk("B release ready", 32'(ready), 32'd1);

        // randomized frames from idle
        for (int i = 0; i < 10; i++)
            do_frame($sformatf("R%0d", i), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 4)), 8'($urandom), 8'($urandom));

        // start while busy is ignored
        loop = 1'b1;
        arm(0, 0, 0, 8'h00);
        cs_sel = 2'd1; cpol = 0; cpha = 0; lsb_first = 0; hold_cs = 0; dvsr = 16'd1;
        din = 8'h5A; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (6) cyc();
        din = 8'hFF; cs_sel = 2'd3; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy ss_n", 32'(ss_n), 32'hD);
        lat = 7;
        while (done !== 1'b1 && lat < 20000) begin
            cyc();
            lat++;
        end
        chk("busy latency", lat, (2 * DW + 2) * 2);
        chk("busy dout", 32'(dout), 32'h5A);
        cyc();
        slv_on = 1'b0;

        // reset in the middle of bit 3
        arm(0, 0, 0, 8'h00);
        cs_sel = 2'd0; dvsr = 16'd3; din = 8'h96; start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (slv_lead < 4 && n < 2000) begin
            cyc();
            n++;
        end
        chk("midrst reach bit3", 32'(slv_lead >= 4), 32'd1);
        slv_on = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst ss_n", 32'(ss_n), 32'hF);
        chk("midrst ready", 32'(ready), 32'd1);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst sclk", 32'(sclk), 32'd0);
        cyc();
        rst = 1'b1;
        seen = 0;
        repeat (200) begin
            cyc();
            if (done === 1'b1) seen++;
        end
        chk("midrst no done", seen, 0);

        // 3-select instance: cs_sel=3 is out of range
        cs_sel_b = 2'd3; din_b = 16'h1234; start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        chk("ncs3 ready", 32'(ready_b), 32'd1);
        seen = 0;
        repeat (50) begin
            cyc();
            if (done_b === 1'b1 || ss_n_b !== 3'b111) seen++;
        end
        chk("ncs3 ignored", seen, 0);

        // 16-bit loopback at sclk = clk/2
        cs_sel_b = 2'd1; din_b = 16'hBEEF; start_b = 1'b1;
        cyc();
        start_b = 1'b0; din_b = 16'h0000;
        chk("dw16 ss_n", 32'(ss_n_b), 32'h5);
        lat = 0;
        while (done_b !== 1'b1 && lat < 20000) begin
            cyc();
            lat++;
        end
        chk("dw16 latency", lat, (2 * 16 + 2) * 1);
        chk("dw16 dout", 32'(dout_b), 32'hBEEF);
        cyc();
        chk("dw16 ss_n_after", 32'(ss_n_b), 32'h7);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
